// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: raster timing, frame-buffer read addressing with integer
// upscaling, and RGB332 -> 4:4:4 colour expansion aligned to the BRAM read latency.
module vga_fb_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int ADDR_W   = 19,
   parameter int RD_LAT   = 2,
   parameter int SYNC_POL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        scale_sel,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [7:0]        fb_data,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              active,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W    = $clog2(H_TOTAL);
   localparam int VC_W    = $clog2(V_TOTAL);
   localparam int PIPE    = RD_LAT + 2;

   localparam logic [HC_W-1:0] H_VIS    = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
   localparam logic [VC_W-1:0] V_VIS    = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);

   localparam logic [ADDR_W-1:0] STEP_X1 = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] STEP_X2 = ADDR_W'(H_ACTIVE / 2);
   localparam logic [ADDR_W-1:0] STEP_X4 = ADDR_W'(H_ACTIVE / 4);

   localparam logic SYNC_LVL = (SYNC_POL != 0);

   logic [HC_W-1:0]   hc_reg, hc_next;
   logic [VC_W-1:0]   vc_reg, vc_next;
   logic [1:0]        s_reg, s_next;
   logic [ADDR_W-1:0] row_base_reg, row_base_next;
   logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
   logic [ADDR_W-1:0] row_step, col;
   logic              line_end, row_adv;
   logic              vis0, hs0, vs0, fs0;

   logic [PIPE-1:0]   act_pipe_reg, hs_pipe_reg, vs_pipe_reg, fs_pipe_reg;
   logic [3:0]        r_reg, g_reg, b_reg;

   always_comb begin
      line_end = (hc_reg == H_LAST);
      hc_next  = hc_reg + 1'b1;
      vc_next  = vc_reg;
      if (line_end) begin
         hc_next = '0;
         vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
      end
   end

   always_comb begin
      vis0 = (hc_reg < H_VIS) && (vc_reg < V_VIS);
      hs0  = (hc_reg >= HS_START) && (hc_reg < HS_END);
      vs0  = (vc_reg >= VS_START) && (vc_reg < VS_END);
      fs0  = (hc_reg == '0) && (vc_reg == '0);
   end

   // Scale only changes at the top-left corner so a frame never mixes mappings.
   always_comb begin
      s_next = s_reg;
      if (fs0) begin
         case (scale_sel)
            2'b01:   s_next = 2'd1;
            2'b10:   s_next = 2'd2;
            default: s_next = 2'd0;
         endcase
      end
   end

   // Row base advances by the scaled line width once every 2^s lines,
   // i.e. when the line just finished is the last of its replicated group.
   always_comb begin
      case (s_reg)
         2'd1: begin
            row_step = STEP_X2;
            row_adv  = vc_reg[0];
         end
         2'd2: begin
            row_step = STEP_X4;
            row_adv  = &vc_reg[1:0];
         end
         default: begin
            row_step = STEP_X1;
            row_adv  = 1'b1;
         end
      endcase
      col           = ADDR_W'(hc_reg >> s_reg);
      row_base_next = row_base_reg;
      if (line_end) begin
         if (vc_reg == V_LAST)
            row_base_next = '0;
         else if (row_adv)
            row_base_next = row_base_reg + row_step;
      end
      fb_addr_next = vis0 ? (row_base_reg + col) : fb_addr_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hc_reg       <= '0;
         vc_reg       <= '0;
         s_reg        <= 2'd0;
         row_base_reg <= '0;
         fb_addr_reg  <= '0;
      end else begin
         hc_reg       <= hc_next;
         vc_reg       <= vc_next;
         s_reg        <= s_next;
         row_base_reg <= row_base_next;
         fb_addr_reg  <= fb_addr_next;
      end
   end

   // Stage PIPE-2 of the active pipe lines up with fb_data for the same pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_pipe_reg <= '0;
         fs_pipe_reg  <= '0;
         hs_pipe_reg  <= {PIPE{~SYNC_LVL}};
         vs_pipe_reg  <= {PIPE{~SYNC_LVL}};
         r_reg        <= 4'd0;
         g_reg        <= 4'd0;
         b_reg        <= 4'd0;
      end else begin
         act_pipe_reg <= {act_pipe_reg[PIPE-2:0], vis0};
         fs_pipe_reg  <= {fs_pipe_reg[PIPE-2:0], fs0};
         hs_pipe_reg  <= {hs_pipe_reg[PIPE-2:0], hs0 ? SYNC_LVL : ~SYNC_LVL};
         vs_pipe_reg  <= {vs_pipe_reg[PIPE-2:0], vs0 ? SYNC_LVL : ~SYNC_LVL};
         if (act_pipe_reg[PIPE-2]) begin
            r_reg <= {fb_data[7:5], fb_data[7]};
            g_reg <= {fb_data[4:2], fb_data[4]};
            b_reg <= {fb_data[1:0], fb_data[1:0]};
         end else begin
            r_reg <= 4'd0;
            g_reg <= 4'd0;
            b_reg <= 4'd0;
         end
      end
   end

   assign fb_addr     = fb_addr_reg;
   assign vga_hs      = hs_pipe_reg[PIPE-1];
   assign vga_vs      = vs_pipe_reg[PIPE-1];
   assign active      = act_pipe_reg[PIPE-1];
   assign frame_start = fs_pipe_reg[PIPE-1];
   assign vga_r       = r_reg;
   assign vga_g       = g_reg;
   assign vga_b       = b_reg;

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Parametrised VGA scan-out engine: generates display timing, the frame-buffer read address and expanded 4:4:4 colour in one clock domain.
- Supports integer upscaling (×1/×2/×4) so smaller frame buffers fill the full raster.
- Compensates a configurable BRAM read latency, so syncs, active and colour stay aligned.
- Sits between the pixel-clock domain of the frame-buffer BRAM read port and the VGA pins.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: hsync width
- H_BP, 48: horizontal back porch
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch
- V_SYNC, 2: vsync width (lines)
- V_BP, 33: vertical back porch
- ADDR_W, 19: frame-buffer address width
- RD_LAT, 2: BRAM read latency in cycles, fb_addr to fb_data (≥1)
- SYNC_POL, 0: sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- scale_sel  in  2  00 = ×1, 01 = ×2, 10 = ×4, 11 = ×1 (reserved)
- fb_addr  out  ADDR_W  frame-buffer read address
- fb_data  in  8  pixel from BRAM, RGB332 {R[7:5], G[4:2], B[1:0]}
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- active  out  1  output pixel is visible
- frame_start  out  1  one-cycle pulse with output pixel (0,0)

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst.
- Reset values:
  - hc = vc = 0.
  - fb_addr = 0.
  - vga_hs and vga_vs at inactive level (~SYNC_POL).
  - Colour 0, active = 0, frame_start = 0.
  - All pipeline stages cleared to the blank/inactive state.
  - Scale register = ×1.
- Reset mid-frame: same state; the raster restarts at (0,0) on the first cycle after rst deasserts.
- Counters:
  - hc counts 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - vc increments when hc wraps; vc counts 0..V_TOTAL-1 (525) and wraps to 0.
- Stage-0 timing (at the counters):
  - Visible: hc < H_ACTIVE and vc < V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for the analogous range of vc, for whole lines.
- Scale: s = 0/1/2 (shift amount), latched from scale_sel only when the counters are at (0,0). A change mid-frame takes effect at the next frame.
- Address:
  - fb_addr is registered and presented 1 cycle after the counters hold (hc,vc).
  - Value = (vc>>s)*(H_ACTIVE>>s) + (hc>>s).
  - Implemented incrementally with a row-base register; no multiplier.
  - Outside the visible region fb_addr holds its last value.
  - Last visible pixel gives 307199 at ×1, 76799 at ×2, 19199 at ×4. The next frame restarts at 0.
- Latency:
  - vga_hs, vga_vs, active, colour and frame_start for position (hc,vc) all appear PIPE = RD_LAT+2 cycles after the counters hold that position.
  - Sync and active are delayed through a PIPE-deep shift register.
  - Colour is registered from fb_data, which is sampled RD_LAT cycles after fb_addr.
- Colour expansion (registered output):
  - vga_r = {R[2:0], R[2]}
  - vga_g = {G[2:0], G[2]}
  - vga_b = {B[1:0], B[1:0]}
  - Forced to 0 when the delayed active = 0, regardless of fb_data.
- frame_start: asserted exactly one cycle per frame, coincident with active = 1 for pixel (0,0).
- Widths: H_ACTIVE*V_ACTIVE-1 must fit in ADDR_W; no saturation logic.

Test Plan:
- Reset: hold rst 5 cycles with fb_data = 0xFF -> vga_hs = vga_vs = 1, colour 0, active 0, fb_addr 0. After release, the first hsync edge is 656+PIPE cycles later.
- Timing, defaults: run 2 frames -> vga_hs low 96 of every 800 cycles; vga_vs low 1600 of every 420000 cycles; active high 640 per line on 480 lines; one frame_start per 420000 cycles.
- Address ×1 (scale_sel = 00, BRAM model with RD_LAT = 2 returning addr[7:0]) -> fb_addr = 0, 639, 640 at (0,0), (639,0), (0,1); last = 307199. Output colour matches the data for the same pixel, with delay PIPE = 4.
- Address ×2, then ×4:
  - ×2: (0,0), (1,0), (0,1), (1,1) -> fb_addr 0; (2,0) -> 1; (0,2) -> 320; last 76799.
  - ×4: last = 19199.
  - Switching scale_sel at vc = 100 changes the mapping only from the next frame.
- Colour:
  - fb_data 0xE3 -> r = F, g = 0, b = F.
  - fb_data 0x49 -> r = 4, g = 4, b = 5.
  - fb_data 0xFF during blanking -> r = g = b = 0.
- Mid-frame reset: assert rst 1 cycle at vc = 200 -> outputs return to reset values next cycle; the raster restarts at (0,0) and fb_addr sequence restarts at 0.
